// File: rtl/blk_tx_sched.sv
// Block-atomic round-robin scheduler: moves whole blocks from NSRC FWFT FIFOs onto one
// 16-bit TX lane, with comma idle fill, inter-block comma and pre-emptive trigger word.
module blk_tx_sched #(
    parameter int unsigned NSRC = 17,
    parameter int unsigned TMO  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [NSRC*16-1:0]   src_data,
    output logic [NSRC-1:0]      src_rd,
    input  logic                 trig,
    output logic [15:0]          dataout,
    output logic                 kchar,
    output logic [4:0]           grant,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    localparam int unsigned GW = 5;
    localparam int unsigned LW = 9;
    localparam int unsigned TW = 16;
    localparam int unsigned EW = 8;
    localparam logic [15:0] K28_5 = 16'h00BC;
    localparam logic [15:0] K28_0 = 16'h801C;

    typedef enum logic [1:0] {SEL, HDR, COPY, GAP} state_t;

    state_t          state, state_d;
    logic [GW-1:0]   grant_d;
    logic [LW-1:0]   remaining, rem_d;
    logic [TW-1:0]   tmr, tmr_d;
    logic            rd_en, keep_data, err_inc;
    logic [15:0]     head;
    logic            head_valid;
    logic            found;
    logic [GW-1:0]   found_idx;
    logic [NSRC-1:0] rot;
    logic [GW:0]     sum;

    // Head word and valid of the currently granted FIFO
    always_comb begin
        head       = '0;
        head_valid = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (grant == GW'(i)) begin
                head       = src_data[16*i +: 16];
                head_valid = src_valid[i];
            end
        end
    end

    // Round-robin search: rotate valids so bit 0 is the source after grant
    always_comb begin
        found     = 1'b0;
        found_idx = grant;
        sum       = '0;
        rot       = NSRC'({src_valid, src_valid} >> (grant + GW'(1)));
        for (int unsigned j = 0; j < NSRC; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                sum   = (GW+1)'(grant) + (GW+1)'(j) + (GW+1)'(1);
                if (sum >= (GW+1)'(NSRC)) begin
                    sum = sum - (GW+1)'(NSRC);
                end
                found_idx = sum[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEL;
        end else begin
            state <= state_d;
        end
    end

    // Next state and datapath controls; a trigger cycle freezes everything
    always_comb begin
        state_d   = state;
        grant_d   = grant;
        rem_d     = remaining;
        tmr_d     = tmr;
        rd_en     = 1'b0;
        keep_data = 1'b0;
        err_inc   = 1'b0;
        if (!trig) begin
            case (state)
                SEL: begin
                    if (found) begin
                        grant_d = found_idx;
                        state_d = HDR;
                    end
                end
                HDR: begin
                    if (!head_valid) begin
                        state_d = SEL;
                    end else if (!head[15]) begin
                        rd_en   = 1'b1;
                        err_inc = 1'b1;
                        state_d = SEL;
                    end else begin
                        rd_en     = 1'b1;
                        keep_data = 1'b1;
                        rem_d     = head[LW-1:0];
                        tmr_d     = '0;
                        state_d   = (head[LW-1:0] == '0) ? GAP : COPY;
                    end
                end
                COPY: begin
                    if (head_valid) begin
                        rd_en     = 1'b1;
                        keep_data = 1'b1;
                        tmr_d     = '0;
                        rem_d     = remaining - LW'(1);
                        if (remaining == LW'(1)) begin
                            state_d = GAP;
                        end
                    end else if (tmr >= TW'(TMO - 1)) begin
                        // Underrun too long: abandon the block, receiver sees short length
                        err_inc = 1'b1;
                        tmr_d   = '0;
                        state_d = GAP;
                    end else begin
                        tmr_d = tmr + TW'(1);
                    end
                end
                GAP: begin
                    state_d = SEL;
                end
                default: begin
                    state_d = SEL;
                end
            endcase
        end
    end

    always_comb begin
        src_rd = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src_rd[i] = rd_en && (grant == GW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant     <= GW'(NSRC - 1);
            remaining <= '0;
            tmr       <= '0;
            dataout   <= K28_5;
            kchar     <= 1'b1;
            busy      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            grant     <= grant_d;
            remaining <= rem_d;
            tmr       <= tmr_d;
            busy      <= (state_d == HDR) || (state_d == COPY);
            kchar     <= trig || !keep_data;
            if (trig) begin
                dataout <= K28_0;
            end else if (keep_data) begin
                dataout <= head;
            end else begin
                dataout <= K28_5;
            end
            if (err_inc && (err_cnt != {EW{1'b1}})) begin
                err_cnt <= err_cnt + EW'(1);
            end
        end
    end

endmodule

// File: tb/tb_blk_tx_sched.sv
// Self-checking bench for blk_tx_sched: FIFO models feed the DUT and a block-level
// round-robin model predicts the TX word stream, trigger words and error count.
module tb_blk_tx_sched;

    localparam int NSRC = 17;
    localparam int TMO  = 4;

    logic                clk;
    logic                reset;
    logic [NSRC-1:0]     src_valid;
    logic [NSRC*16-1:0]  src_data;
    logic [NSRC-1:0]     src_rd;
    logic                trig;
    logic [15:0]         dataout;
    logic                kchar;
    logic [4:0]          grant;
    logic                busy;
    logic [7:0]          err_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0]     mem [NSRC][256];
    int              hd [NSRC];
    int              tl [NSRC];
    logic [NSRC-1:0] mask;
    int              m_grant;
    int              m_err;
    logic [16:0]     exp_q [$];

    localparam logic [16:0] COMMA = {1'b1, 16'h00BC};
    localparam logic [16:0] TRIGW = {1'b1, 16'h801C};

    blk_tx_sched #(.NSRC(NSRC), .TMO(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_rd    (src_rd),
        .trig      (trig),
        .dataout   (dataout),
        .kchar     (kchar),
        .grant     (grant),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < NSRC; i++) begin
            src_valid[i] = (hd[i] < tl[i]) && !mask[i];
            src_data[16*i +: 16] = src_valid[i] ? mem[i][hd[i]] : 16'h0000;
        end
    endtask

    task automatic push(input int s, input logic [15:0] w);
        mem[s][tl[s]] = w;
        tl[s]++;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NSRC; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        mask = '0;
    endtask

    // One clock: check read legality just before the edge, pop what was read
    task automatic cycle(input logic t);
        logic [NSRC-1:0] rd;
        trig = t;
        #8;
        rd = src_rd;
        checks++;
        if ($countones(rd) > 1 || (rd & ~src_valid) != '0 || (t && rd != '0)) begin
            errors++;
            $display("FAIL rd_legal: src_rd=%h src_valid=%h trig=%0b", rd, src_valid, t);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NSRC; i++) begin
            if (rd[i]) hd[i]++;
        end
        trig = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trig  = 1'b0;
        clear_fifos();
        drive();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_grant = NSRC - 1;
        m_err   = 0;
    endtask

    // Expected base stream from queued blocks: SEL comma, block words, GAP comma per block
    task automatic build_model();
        int p [NSRC];
        int g;
        int i;
        int len;
        logic [15:0] h;
        exp_q.delete();
        for (int s = 0; s < NSRC; s++) p[s] = hd[s];
        g = m_grant;
        for (int n = 0; n < 4000; n++) begin
            i = -1;
            for (int k = 1; k <= NSRC; k++) begin
                int c;
                c = (g + k) % NSRC;
                if (i < 0 && p[c] < tl[c] && !mask[c]) i = c;
            end
            if (i < 0) break;
            g = i;
            exp_q.push_back(COMMA);
            h = mem[i][p[i]];
            p[i]++;
            if (!h[15]) begin
                exp_q.push_back(COMMA);
                if (m_err < 255) m_err++;
                continue;
            end
            exp_q.push_back({1'b0, h});
            len = int'(h[8:0]);
            for (int j = 0; j < len; j++) begin
                exp_q.push_back({1'b0, mem[i][p[i]]});
                p[i]++;
            end
            exp_q.push_back(COMMA);
        end
        m_grant = g;
    endtask

    // Run until the predicted stream is drained; a trigger cycle yields 801C and shifts the rest
    task automatic run_model(input logic [63:0] tpat, input int tprob, input string name);
        int ptr;
        int tail_cnt;
        int c;
        logic t;
        logic [16:0] exp;
        build_model();
        ptr = 0;
        tail_cnt = 0;
        c = 0;
        while (tail_cnt < 3 && c < 3000) begin
            t = ((c < 64) ? tpat[c] : 1'b0) || (int'($urandom_range(99)) < tprob);
            cycle(t);
            if (t) exp = TRIGW;
            else if (ptr < exp_q.size()) begin
                exp = exp_q[ptr];
                ptr++;
            end else exp = COMMA;
            checks++;
            if ({kchar, dataout} !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got k=%0b d=%h expected k=%0b d=%h",
                         name, c, kchar, dataout, exp[16], exp[15:0]);
            end
            if (ptr >= exp_q.size()) tail_cnt++;
            c++;
        end
        checks++;
        if (c >= 3000) begin
            errors++;
            $display("FAIL %s timeout: got %0d cycles expected under 3000", name, c);
        end
        checks++;
        if (grant !== 5'(m_grant)) begin
            errors++;
            $display("FAIL %s grant: got %0d expected %0d", name, grant, m_grant);
        end
        checks++;
        if (err_cnt !== 8'(m_err)) begin
            errors++;
            $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, m_err);
        end
        for (int i = 0; i < NSRC; i++) begin
            checks++;
            if (!mask[i] && hd[i] != tl[i]) begin
                errors++;
                $display("FAIL %s drain src%0d: got %0d left expected 0", name, i, tl[i] - hd[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({kchar, dataout, grant, busy, err_cnt} !== {1'b1, 16'h00BC, 5'd16, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_vals: got k=%0b d=%h g=%0d b=%0b e=%0d expected k=1 d=00bc g=16 b=0 e=0",
                     kchar, dataout, grant, busy, err_cnt);
        end
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0);
            checks++;
            if ({kchar, dataout} !== COMMA || src_rd !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got k=%0b d=%h rd=%h expected k=1 d=00bc rd=0",
                         c, kchar, dataout, src_rd);
            end
        end
    endtask

    task automatic test_block();
        do_reset();
        push(3, 16'h8003); push(3, 16'h0011); push(3, 16'h0022); push(3, 16'h0033);
        drive();
        run_model(64'h0, 0, "block_fifo3");
    endtask

    task automatic test_round_robin();
        do_reset();
        push(0, 16'h8001); push(0, 16'hA0A0); push(0, 16'h8000);
        push(16, 16'h8002); push(16, 16'hB1B1); push(16, 16'hB2B2);
        push(16, 16'h8001); push(16, 16'hB3B3);
        drive();
        run_model(64'h0, 0, "rr_order");
    endtask

    task automatic test_trigger();
        do_reset();
        push(3, 16'h8003); push(3, 16'h0011); push(3, 16'h0022); push(3, 16'h0033);
        drive();
        run_model(64'h8, 0, "trig_payload");
        push(3, 16'h8003); push(3, 16'h0044); push(3, 16'h0055); push(3, 16'h0066);
        drive();
        run_model(64'h30, 0, "trig_block_end");
    endtask

    task automatic test_bad_header();
        do_reset();
        push(5, 16'h1234);
        push(7, 16'h8001); push(7, 16'h00AA);
        drive();
        run_model(64'h0, 0, "bad_header");
    endtask

    task automatic test_timeout();
        logic [16:0] e6 [9];
        do_reset();
        push(2, 16'h8005); push(2, 16'h0001); push(2, 16'h0002);
        drive();
        e6[0] = COMMA; e6[1] = {1'b0, 16'h8005}; e6[2] = {1'b0, 16'h0001};
        e6[3] = {1'b0, 16'h0002};
        for (int c = 4; c < 9; c++) e6[c] = COMMA;
        for (int c = 0; c < 9; c++) begin
            cycle(1'b0);
            checks++;
            if ({kchar, dataout} !== e6[c] || err_cnt !== ((c >= 7) ? 8'd1 : 8'd0)
                || busy !== (c <= 6)) begin
                errors++;
                $display("FAIL timeout cycle %0d: got k=%0b d=%h e=%0d b=%0b expected k=%0b d=%h e=%0d b=%0b",
                         c, kchar, dataout, err_cnt, busy, e6[c][16], e6[c][15:0],
                         (c >= 7) ? 1 : 0, (c <= 6) ? 1 : 0);
            end
        end
        m_grant = 2;
        m_err   = 1;
        push(2, 16'h8000);
        drive();
        run_model(64'h0, 0, "hdr_only");
    endtask

    task automatic test_mid_reset();
        do_reset();
        push(3, 16'h8004); push(3, 16'h0001); push(3, 16'h0002);
        push(3, 16'h0003); push(3, 16'h0004);
        drive();
        cycle(1'b0); cycle(1'b0); cycle(1'b0);
        reset = 1'b1;
        cycle(1'b0);
        checks++;
        if ({kchar, dataout, grant, busy, err_cnt} !== {1'b1, 16'h00BC, 5'd16, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset: got k=%0b d=%h g=%0d b=%0b e=%0d expected k=1 d=00bc g=16 b=0 e=0",
                     kchar, dataout, grant, busy, err_cnt);
        end
        reset = 1'b0;
        clear_fifos();
        drive();
        m_grant = NSRC - 1;
        m_err   = 0;
        run_model(64'h0, 0, "post_reset_idle");
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int n = 0; n < 130; n++) begin
            push(9, 16'h0100 + 16'(n));
            push(12, 16'h0200 + 16'(n));
        end
        drive();
        run_model(64'h0, 0, "err_saturate");
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 4; it++) begin
            clear_fifos();
            for (int s = 0; s < NSRC; s++) begin
                int nb;
                nb = int'($urandom_range(2));
                for (int b = 0; b < nb; b++) begin
                    if ($urandom_range(9) == 0) begin
                        push(s, {1'b0, 15'($urandom)});
                    end else begin
                        int len;
                        len = int'($urandom_range(6));
                        push(s, {1'b1, 6'($urandom), 9'(len)});
                        for (int j = 0; j < len; j++) push(s, 16'($urandom));
                    end
                end
            end
            drive();
            run_model(64'h0, 20, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        trig  = 1'b0;
        clear_fifos();
        drive();
        @(posedge clk);
        #1;
        test_reset();
        test_block();
        test_round_robin();
        test_trigger();
        test_bad_header();
        test_timeout();
        test_mid_reset();
        test_err_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2000000");
        $fatal(1);
    end

endmodule
